// File: rtl/gb_rtc_pkg.sv
// gb_rtc_pkg: shared states, save-file word indices, packed RTC field layout and limits
package gb_rtc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_COMMIT, S_SAVE} state_t;
  localparam logic [2:0] TS_LO = 3'd0;
  localparam logic [2:0] TS_HI = 3'd1;
  localparam logic [2:0] ST_LO = 3'd2;
  localparam logic [2:0] ST_HI = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;
  localparam int SEC_LSB = 0;
  localparam int SEC_W = 6;
  localparam int MIN_LSB = 6;
  localparam int MIN_W = 6;
  localparam int HR_LSB = 12;
  localparam int HR_W = 5;
  localparam int DAY_LSB = 17;
  localparam int DAY_W = 10;
  localparam int OVF_BIT = 27;
  localparam int HALT_BIT = 28;
  localparam int RSV_LSB = 29;
  localparam logic [SEC_W-1:0] SEC_LIM = 6'd60;
  localparam logic [MIN_W-1:0] MIN_LIM = 6'd60;
  localparam logic [HR_W-1:0] HR_LIM = 5'd24;
endpackage

// File: rtl/gb_rtc_field_check.sv
// gb_rtc_field_check: combinational range check of packed RTC registers
// ports: savedtime (packed sec/min/hr/day/ovf/halt), ok (all fields in range, reserved bits zero)
module gb_rtc_field_check
  import gb_rtc_pkg::*;
(
  input  logic [31:0] savedtime,
  output logic        ok
);
  logic [SEC_W-1:0] w_sec;
  logic [MIN_W-1:0] w_min;
  logic [HR_W-1:0] w_hr;
  assign w_sec = savedtime[SEC_LSB +: SEC_W];
  assign w_min = savedtime[MIN_LSB +: MIN_W];
  assign w_hr = savedtime[HR_LSB +: HR_W];
  assign ok = (w_sec < SEC_LIM) && (w_min < MIN_LIM) && (w_hr < HR_LIM) && (savedtime[31:RSV_LSB] == '0);
endmodule

// File: rtl/gb_rtc_bk.sv
// gb_rtc_bk: loads RTC words from a save file into the mapper (validated) and streams live RTC state out for saving
// ports: clk_sys/reset_n; enable; ld_start/ld_valid/ld_data/ld_ready load stream; sv_start/sv_valid/sv_data/sv_ready save stream;
//        RTC_timestampOut/RTC_savedtimeOut live mapper state; bk_rtc_wr/bk_addr/bk_data mapper load port; busy/done/err status
module gb_rtc_bk
  import gb_rtc_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ld_start,
  input  logic        ld_valid,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  input  logic        sv_start,
  output logic        sv_valid,
  output logic [15:0] sv_data,
  input  logic        sv_ready,
  input  logic [31:0] RTC_timestampOut,
  input  logic [31:0] RTC_savedtimeOut,
  output logic        bk_rtc_wr,
  output logic [16:0] bk_addr,
  output logic [15:0] bk_data,
  output logic        busy,
  output logic        done,
  output logic        err
);
  state_t r_state;
  logic [1:0] r_cnt;
  logic r_wr, r_done, r_err;
  logic [2:0] r_addr;
  logic [15:0] r_bk_data, r_st_lo, r_st_hi;
  logic [63:0] r_snap;
  logic w_ok, w_ld_hs;
  gb_rtc_field_check u_check (.savedtime({r_st_hi, r_st_lo}), .ok(w_ok));
  // ready is withheld while enable is low so an aborting cycle cannot schedule a write
  assign ld_ready = (r_state == S_LOAD) && enable;
  assign w_ld_hs = ld_ready && ld_valid;
  assign sv_valid = r_state == S_SAVE;
  assign sv_data = sv_valid ? r_snap[{r_cnt, 4'd0} +: 16] : '0;
  assign bk_rtc_wr = r_wr;
  assign bk_addr = {14'd0, r_addr};
  assign bk_data = r_bk_data;
  assign busy = r_state != S_IDLE;
  assign done = r_done;
  assign err = r_err;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_wr <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_bk_data <= '0;
      r_st_lo <= '0;
      r_st_hi <= '0;
      r_snap <= '0;
    end else begin
      r_wr <= 1'b0;
      r_done <= 1'b0;
      if (r_state != S_IDLE && !enable) begin
        r_state <= S_IDLE;
        r_cnt <= '0;
        r_done <= 1'b1;
      end else
        case (r_state)
          S_IDLE:
            if (ld_start && enable) begin
              r_state <= S_LOAD;
              r_cnt <= '0;
              r_err <= 1'b0;
            end else if (sv_start && enable) begin
              r_state <= S_SAVE;
              r_cnt <= '0;
              r_snap <= {RTC_savedtimeOut, RTC_timestampOut};
            end
          S_LOAD:
            if (w_ld_hs) begin
              r_wr <= 1'b1;
              r_addr <= {1'b0, r_cnt};
              r_bk_data <= ld_data;
              r_cnt <= r_cnt + 2'd1;
              if (r_cnt == ST_LO[1:0]) r_st_lo <= ld_data;
              if (r_cnt == ST_HI[1:0]) begin
                r_st_hi <= ld_data;
                r_state <= S_CHECK;
              end
            end
          S_CHECK:
            if (w_ok) r_state <= S_COMMIT;
            else begin
              r_err <= 1'b1;
              r_done <= 1'b1;
              r_state <= S_IDLE;
            end
          S_COMMIT: begin
            r_wr <= 1'b1;
            r_addr <= COMMIT;
            r_bk_data <= '0;
            r_done <= 1'b1;
            r_state <= S_IDLE;
          end
          S_SAVE:
            if (sv_ready) begin
              r_cnt <= r_cnt + 2'd1;
              if (r_cnt == ST_HI[1:0]) begin
                r_done <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          default: r_state <= S_IDLE;
        endcase
    end
endmodule
